fetch: RTL and testbench
========================

// Module: fetch
// PURPOSE
//  Front-end instruction fetch stage, directly upstream of decode. Holds the PC,
//  issues sequential requests to a synchronous instruction memory, and pairs each
//  returned word with its PC. The pairs are buffered in a small FIFO and presented
//  to decode over a valid/ready handshake.
//  Accepts a redirect (mispredict/exception) that flushes all fetch state and
//  restarts at a new PC.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC of the first fetch after reset
//  DEPTH     4              instruction-queue entries (power of 2, >=2)
// PORTS
//  clk             in   1   clock, all state on posedge
//  reset           in   1   asynchronous, active-low reset (0 = in reset)
//  imem_req        out  1   request valid this cycle
//  imem_addr       out  32  word-aligned fetch address (= pc_q)
//  imem_rdata      in   32  instruction for the request issued the previous cycle
//  redirect_valid  in   1   flush and restart fetch at redirect_pc
//  redirect_pc     in   32  new PC; bits [1:0] are ignored and forced to 0
//  instr           out  32  head-of-queue instruction, to decode.instr
//  pc_out          out  32  head-of-queue PC, to decode.pc_in
//  valid_out       out  1   queue non-empty, to decode.valid_in
//  ready_in        in   1   decode ready, from decode.ready_in
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - pc_q=RESET_PC; queue empty (count_q=0, head/tail=0); inflight_q=0.
//   - valid_out=0, imem_req=0, instr=0, pc_out=0.
//  Memory timing:
//   - Request in cycle N (imem_req=1, imem_addr=pc_q) -> imem_rdata valid in N+1.
//   - inflight_q=1 and inflight_pc_q record the outstanding request.
//  Issue rule:
//   - deq = valid_out & ready_in.
//   - imem_req = ~redirect_valid & (count_q + inflight_q - deq < DEPTH).
//   - When imem_req=1: pc_q <= pc_q + 4 (32-bit wrap, no trap at 32'hFFFF_FFFC).
//  Enqueue:
//   - If inflight_q=1 and no redirect this cycle, write {inflight_pc_q, imem_rdata}
//     at the tail on the edge ending the cycle.
//   - Never overflows, by the issue rule.
//  Latency:
//   - Request cycle N -> valid_out cycle N+2 (empty queue).
//   - First request is the first cycle after reset release -> valid_out 2 cycles
//     later with pc_out=RESET_PC.
//   - Steady state with ready_in=1: one instruction per cycle.
//  Dequeue: on deq, the head advances. instr/pc_out come from the head entry.
//   - Outputs are stable while valid_out=1 & ready_in=0.
//  Simultaneous enq+deq at full or empty: count_q unchanged, both pointers advance.
//  Redirect (cycle R, highest priority):
//   - No request in R.
//   - Response arriving in R is dropped.
//   - Queue cleared: count_q=0, valid_out=0 from R+1; inflight_q<=0.
//   - pc_q <= {redirect_pc[31:2],2'b00}.
//   - Request to the new PC in R+1; valid_out in R+3.
//   - Applies regardless of ready_in.
//   - Redirect on back-to-back cycles: the last one wins.
//  Reset mid-operation: immediate return to reset state.
//   - Any in-flight response is ignored.
//  Pointers: log2(DEPTH) bits, natural wrap. count_q: log2(DEPTH)+1 bits.
// TESTING
//  1 Release reset, ready_in=1, imem returns addr^32'h13:
//    - imem_addr 0,4,8... on consecutive cycles.
//    - valid_out rises 2 cycles later with pc_out=0, instr=32'h13.
//    - Then one instruction per cycle.
//  2 ready_in=0 from start:
//    - Exactly DEPTH=4 requests issued (0..C); imem_req then stays 0.
//    - valid_out=1 with pc_out=0 held.
//    - Raising ready_in drains PCs 0,4,8,C in order and fetching resumes at 0x10.
//  3 Steady stream, redirect_valid=1, redirect_pc=32'h0000_0103 for one cycle:
//    - The next cycle's imem_addr is 0x100.
//    - No old PC reaches decode.
//    - First post-redirect pc_out is 0x100, 3 cycles after the redirect.
//  4 Full queue (ready_in=0) with redirect: valid_out drops the next cycle.
//    - Then refill from redirect_pc.
//  5 Redirect to 32'hFFFF_FFFC:
//    - Fetch addresses FFFF_FFFC then 0000_0000 (wrap).
//    - pc_out sequence matches.
//  6 Assert reset while queue holds 3 entries and a request is in flight:
//    - valid_out=0 and imem_req=0 immediately (async).
//    - After release, fetch restarts at RESET_PC; stale data is never output.

Source files
------------

// File: rtl/fetch.sv
// Instruction fetch front end: PC, one-deep synchronous imem request tracking,
// and a small {pc, instr} queue presented to decode over valid/ready.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        valid_out,
  input  logic        ready_in
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   inflight_pc_q, inflight_pc_d;
  logic [63:0]   mem_q [DEPTH];

  logic          deq;
  logic          enq;
  logic          issue;
  logic [CW:0]   occ;

  always_comb begin
    valid_out = (count_q != '0);
    deq       = valid_out & ready_in;
    enq       = inflight_q & ~redirect_valid;
    // Occupancy counts the outstanding response so the queue can never overflow.
    occ       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, deq};
    issue     = ~redirect_valid & (occ < (CW+1)'(DEPTH));
    imem_req  = issue & reset;
    imem_addr = pc_q;
    instr     = valid_out ? mem_q[head_q][31:0]  : 32'h0;
    pc_out    = valid_out ? mem_q[head_q][63:32] : 32'h0;

    pc_d          = pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;

    if (redirect_valid) begin
      pc_d       = redirect_pc & 32'hFFFF_FFFC;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (issue) begin
        pc_d          = pc_q + 32'd4;
        inflight_pc_d = pc_q;
      end
      if (enq) tail_d = tail_q + PW'(1);
      if (deq) head_d = head_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(deq);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
    end else begin
      pc_q          <= pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  // Queue storage is data only; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= {inflight_pc_q, imem_rdata};
  end

endmodule

// File: tb/tb_fetch.sv
// Randomized and directed bench for fetch against a queue-based reference model.
module tb_fetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        ready_in;

  always #5 clk = ~clk;

  fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr(instr), .pc_out(pc_out), .valid_out(valid_out), .ready_in(ready_in)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        q[$];
  bit          m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_pc;
  bit          last_req;
  logic [31:0] last_addr;

  logic        obs_req, obs_valid;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  int npass = 0;
  int ntotal = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h13;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    q.delete();
    m_inf    = 1'b0;
    m_inf_pc = 32'h0;
    m_pc     = RESET_PC;
    last_req = 1'b0;
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
    bit exp_valid, deq, exp_req;
    int occ;
    ready_in       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_rdata     = last_req ? memf(last_addr) : $urandom();
    #1;
    obs_req   = imem_req;
    obs_addr  = imem_addr;
    obs_valid = valid_out;
    obs_pc    = pc_out;
    obs_instr = instr;

    exp_valid = (q.size() != 0);
    deq       = exp_valid && rdy;
    occ       = q.size() + int'(m_inf) - int'(deq);
    exp_req   = !rv && (occ < DEPTH);

    chk("valid_out", {31'b0, obs_valid}, {31'b0, exp_valid});
    chk("imem_req", {31'b0, obs_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", obs_addr, m_pc);
    if (exp_valid) begin
      chk("pc_out", obs_pc, q[0].pc);
      chk("instr", obs_instr, q[0].ins);
    end

    last_req  = obs_req;
    last_addr = obs_addr;
    if (rv) begin
      q.delete();
      m_inf = 1'b0;
      m_pc  = rpc & 32'hFFFF_FFFC;
    end else begin
      if (deq) void'(q.pop_front());
      if (m_inf) q.push_back('{pc: m_inf_pc, ins: memf(m_inf_pc)});
      m_inf = exp_req;
      if (exp_req) begin
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int skew);
    #(skew);
    reset = 1'b0;
    #1;
    chk("rst valid_out", {31'b0, valid_out}, 32'h0);
    chk("rst imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst pc_out", pc_out, 32'h0);
    chk("rst instr", instr, 32'h0);
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    int nreq;
    reset          = 1'b0;
    ready_in       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rdata     = 32'h0;
    model_reset();
    @(negedge clk);
    do_reset(0);

    // 1: streaming after reset release
    step(1, 0, 0); chk("t1 addr0", obs_addr, 32'h0); chk("t1 req0", {31'b0, obs_req}, 32'h1);
    step(1, 0, 0); chk("t1 addr1", obs_addr, 32'h4); chk("t1 novalid", {31'b0, obs_valid}, 32'h0);
    step(1, 0, 0); chk("t1 first pc", obs_pc, 32'h0); chk("t1 first instr", obs_instr, 32'h13);
    chk("t1 first valid", {31'b0, obs_valid}, 32'h1);
    step(1, 0, 0); chk("t1 second pc", obs_pc, 32'h4);
    repeat (4) step(1, 0, 0);

    // 2: decode stalled from the start
    do_reset(0);
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0);
      if (obs_req) nreq++;
    end
    chk("t2 nreq", nreq, 4);
    chk("t2 held pc", obs_pc, 32'h0);
    chk("t2 held valid", {31'b0, obs_valid}, 32'h1);
    step(1, 0, 0); chk("t2 drain0", obs_pc, 32'h0); chk("t2 resume", obs_addr, 32'h10);
    step(1, 0, 0); chk("t2 drain1", obs_pc, 32'h4);
    step(1, 0, 0); chk("t2 drain2", obs_pc, 32'h8);
    step(1, 0, 0); chk("t2 drain3", obs_pc, 32'hC);
    repeat (3) step(1, 0, 0);

    // 3: redirect in a steady stream
    step(1, 1, 32'h0000_0103); chk("t3 noreq", {31'b0, obs_req}, 32'h0);
    step(1, 0, 0); chk("t3 newaddr", obs_addr, 32'h100); chk("t3 flushed", {31'b0, obs_valid}, 32'h0);
    step(1, 0, 0); chk("t3 still empty", {31'b0, obs_valid}, 32'h0);
    step(1, 0, 0); chk("t3 first pc", obs_pc, 32'h100); chk("t3 first instr", obs_instr, 32'h113);
    repeat (3) step(1, 0, 0);

    // 4: redirect with a full queue and decode stalled
    repeat (8) step(0, 0, 0);
    step(0, 1, 32'h200);
    step(0, 0, 0); chk("t4 dropped", {31'b0, obs_valid}, 32'h0);
    step(1, 0, 0);
    step(1, 0, 0); chk("t4 refill", obs_pc, 32'h200);
    repeat (3) step(1, 0, 0);

    // 5: address wrap
    step(1, 1, 32'hFFFF_FFFC);
    step(1, 0, 0); chk("t5 addr top", obs_addr, 32'hFFFF_FFFC);
    step(1, 0, 0); chk("t5 addr wrap", obs_addr, 32'h0);
    step(1, 0, 0); chk("t5 pc top", obs_pc, 32'hFFFF_FFFC);
    step(1, 0, 0); chk("t5 pc wrap", obs_pc, 32'h0);

    // back-to-back redirects: the later one wins
    step(1, 1, 32'h300);
    step(1, 1, 32'h400);
    step(1, 0, 0); chk("b2b addr", obs_addr, 32'h400);
    step(1, 0, 0);
    step(1, 0, 0); chk("b2b pc", obs_pc, 32'h400);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      bit rv;
      rv = ($urandom_range(0, 99) < 5);
      step($urandom_range(0, 99) < 70, rv, $urandom());
    end

    // 6: async reset with 3 queued entries and one in flight
    do_reset(0);
    repeat (4) step(0, 0, 0);
    chk("t6 pre valid", {31'b0, obs_valid}, 32'h1);
    ready_in = 1'b0;
    do_reset(2);
    step(1, 0, 0); chk("t6 restart addr", obs_addr, RESET_PC);
    step(1, 0, 0);
    step(1, 0, 0); chk("t6 first pc", obs_pc, RESET_PC); chk("t6 first instr", obs_instr, 32'h13);
    repeat (6) step(1, 0, 0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
